// File: rtl/tproc_pkg.sv
// Shared definitions for the instruction fetch/dispatch stage.
//   OPC_W / OPC_HI_DEFAULT : width and default MSB position of the opcode field
//   OPC_END                : opcode that terminates a program
//   state_e                : fetch/dispatch FSM state encoding
package tproc_pkg;

  localparam int unsigned OPC_W          = 4;
  localparam int unsigned OPC_HI_DEFAULT = 63;

  localparam logic [OPC_W-1:0] OPC_END = 4'h0;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StWaitRd = 3'd2,
    StIssue  = 3'd3,
    StExec   = 3'd4,
    StDone   = 3'd5
  } state_e;

endpackage

// File: rtl/instr_fetch_dispatch.sv
// Instruction fetch/dispatch stage feeding the CLP. A rising edge on acc_enable_i (while idle)
// walks instruction memory from address 0, issuing one instruction at a time over a
// valid/ready handshake and waiting for clp_done_i before fetching the next. Stops at an END
// opcode or at the last memory address (the latter flags prog_err_o).
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   acc_enable_i          start request (rising edge, sampled only when idle)
//   instr_mem_addr_o      instruction memory read address
//   instr_port_i          read data, valid RD_LAT cycles after the address
//   issue_valid_o/ready_i issue handshake; issue_instr_o is the instruction offered
//   clp_done_i            CLP finished the accepted instruction (sampled only in EXEC)
//   busy_o                high outside IDLE
//   prog_done_o           one-cycle pulse at program termination
//   prog_err_o            sticky: ran off the end of memory without END; cleared on start
//   instr_count_o         instructions issued since last start (saturating)
module instr_fetch_dispatch
  import tproc_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned INSTR_W = 64,
  parameter int unsigned OPC_HI  = OPC_HI_DEFAULT,
  parameter int unsigned RD_LAT  = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               acc_enable_i,
  output logic [ADDR_W-1:0]  instr_mem_addr_o,
  input  logic [INSTR_W-1:0] instr_port_i,
  output logic               issue_valid_o,
  input  logic               issue_ready_i,
  output logic [INSTR_W-1:0] issue_instr_o,
  input  logic               clp_done_i,
  output logic               busy_o,
  output logic               prog_done_o,
  output logic               prog_err_o,
  output logic [ADDR_W-1:0]  instr_count_o
);

  localparam logic [ADDR_W-1:0] AddrMax = {ADDR_W{1'b1}};
  // WAITRD lasts RD_LAT cycles: counter runs LatInit..0 and captures on 0.
  localparam logic [1:0]        LatInit = 2'(RD_LAT - 1);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  count_q, count_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [1:0]         lat_q, lat_d;
  logic               err_q, err_d;
  logic               acc_q;
  logic               start;
  logic [OPC_W-1:0]   opcode;

  assign start  = acc_enable_i & ~acc_q;
  assign opcode = instr_port_i[OPC_HI -: OPC_W];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      addr_q  <= '0;
      count_q <= '0;
      instr_q <= '0;
      lat_q   <= '0;
      err_q   <= 1'b0;
      acc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      instr_q <= instr_d;
      lat_q   <= lat_d;
      err_q   <= err_d;
      acc_q   <= acc_enable_i;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    instr_d = instr_q;
    lat_d   = lat_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d  = '0;
          count_d = '0;
          err_d   = 1'b0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        lat_d   = LatInit;
        state_d = StWaitRd;
      end
      StWaitRd: begin
        if (lat_q == 2'd0) begin
          instr_d = instr_port_i;
          state_d = (opcode == OPC_END) ? StDone : StIssue;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      StIssue: begin
        // clp_done_i is deliberately not looked at here.
        if (issue_ready_i) begin
          if (count_q != AddrMax) count_d = count_q + 1'b1;
          state_d = StExec;
        end
      end
      StExec: begin
        if (clp_done_i) begin
          if (addr_q == AddrMax) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = StFetch;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign instr_mem_addr_o = addr_q;
  assign issue_valid_o    = (state_q == StIssue);
  assign issue_instr_o    = instr_q;
  assign busy_o           = (state_q != StIdle);
  assign prog_done_o      = (state_q == StDone);
  assign prog_err_o       = err_q;
  assign instr_count_o    = count_q;

endmodule

// File: tb/tb_instr_fetch_dispatch.sv
// Self-checking bench for instr_fetch_dispatch (ADDR_W=3, RD_LAT=2). A timeline model derives,
// from memory contents and CLP behaviour, the cycle of every transfer and of prog_done; a
// negedge compare process checks all outputs against it every cycle. Directed runs add
// hand-computed literal expectations.
module tb_instr_fetch_dispatch;

  localparam int unsigned AW     = 3;
  localparam int unsigned RD_LAT = 2;
  localparam int          INF    = 32'h7fff_ffff;
  localparam logic [63:0] END_W  = 64'h0123_4567_89ab_cdef;

  logic          clk;
  logic          rst;
  logic          acc_enable;
  logic [AW-1:0] instr_mem_addr;
  logic [63:0]   instr_port;
  logic          issue_valid;
  logic          issue_ready;
  logic [63:0]   issue_instr;
  logic          clp_done;
  logic          busy;
  logic          prog_done;
  logic          prog_err;
  logic [AW-1:0] instr_count;

  instr_fetch_dispatch #(
    .ADDR_W (AW),
    .INSTR_W(64),
    .OPC_HI (63),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .acc_enable_i    (acc_enable),
    .instr_mem_addr_o(instr_mem_addr),
    .instr_port_i    (instr_port),
    .issue_valid_o   (issue_valid),
    .issue_ready_i   (issue_ready),
    .issue_instr_o   (issue_instr),
    .clp_done_i      (clp_done),
    .busy_o          (busy),
    .prog_done_o     (prog_done),
    .prog_err_o      (prog_err),
    .instr_count_o   (instr_count)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 0;

  logic [63:0] mem [8];

  // CLP behaviour knobs
  int cfg_d    = 1;
  int cfg_hold = 0;
  bit cfg_spur = 0;

  // Per-run observations
  int run_xfers = 0;
  int run_dones = 0;
  int last_done = 0;

  // Timeline model
  int          m_s = 0, m_n = 0, m_d = 1, m_done = 0, m_cut = 0;
  int          m_e [8];
  int          m_t [8];
  logic [63:0] m_word [8];
  bit          m_err = 0;
  int          m_prev_count = 0;
  bit          m_prev_err = 0;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Program = words up to the first END (or all 8 words). Each instruction: ISSUE is entered
  // RD_LAT+2 cycles after start or after the previous transfer's clp_done cycle plus
  // RD_LAT+2-... (i.e. d + RD_LAT + 2 after the previous transfer); END leads to DONE at the
  // point the next ISSUE would have begun; running off the end goes to DONE right after EXEC.
  task automatic build_model(input int s, input int d, input int hold);
    int e;
    bit found;
    if (m_cut != INF) begin
      m_prev_count = 0;
      m_prev_err   = 0;
    end else begin
      m_prev_count = imin(m_n, 7);
      m_prev_err   = m_err;
    end
    m_n   = 0;
    found = 0;
    for (int i = 0; i < 8; i++) begin
      if (!found) begin
        if (mem[i][63:60] == 4'h0) found = 1;
        else begin
          m_word[m_n] = mem[i];
          m_n++;
        end
      end
    end
    m_err = !found;
    e = s + RD_LAT + 2;
    for (int i = 0; i < m_n; i++) begin
      m_e[i] = e;
      m_t[i] = e + ((i == 0) ? hold : 0);
      e = m_t[i] + d + RD_LAT + 2;
    end
    if (m_n == 0)  m_done = s + RD_LAT + 2;
    else if (found) m_done = m_t[m_n-1] + d + RD_LAT + 2;
    else            m_done = m_t[m_n-1] + d + 1;
    m_d   = d;
    m_s   = s;
    m_cut = INF;
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Instruction memory with RD_LAT-cycle read latency
  initial begin
    logic [AW-1:0] a;
    logic [63:0]   p0, p1;
    p0 = '0;
    p1 = '0;
    instr_port = '0;
    forever begin
      @(negedge clk);
      a = instr_mem_addr;
      @(posedge clk);
      #1;
      p1 = p0;
      p0 = mem[a];
      instr_port = (RD_LAT == 1) ? p0 : p1;
    end
  end

  // CLP: optional ready stall on the first ISSUE of a run, clp_done cfg_d cycles after each
  // transfer, optional spurious clp_done during the transfer cycle itself.
  initial begin
    int  cnt;
    int  hold_used;
    bit  pend;
    bit  first_done;
    cnt = 0; hold_used = 0; pend = 0; first_done = 0;
    issue_ready = 1;
    clp_done    = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!busy) begin
        cnt = 0; pend = 0; hold_used = 0; first_done = 0;
      end
      if (pend) cnt = cfg_d;
      if (issue_valid && !first_done && hold_used < cfg_hold) begin
        issue_ready = 0;
        hold_used++;
      end else begin
        issue_ready = 1;
      end
      clp_done = (cnt == 1) || (cfg_spur && issue_valid && issue_ready);
      if (cnt > 0) cnt--;
      pend = issue_valid && issue_ready;
      if (pend) first_done = 1;
    end
  end

  // Compare process
  always @(negedge clk) begin
    int          c, nx, na, e_count, e_addr;
    bit          e_busy, e_valid, e_done, e_err, chk_addr, chk_word;
    logic [63:0] e_word;
    if (mon_en) begin
      c = cyc;
      e_busy = 0; e_valid = 0; e_done = 0; e_err = 0; chk_addr = 0; chk_word = 0;
      e_word = '0; e_count = 0; e_addr = 0;
      if (m_cut != INF && c > m_cut) begin
        chk_addr = 1;
        chk_word = 1;
      end else if (c <= m_s) begin
        e_count = m_prev_count;
        e_err   = m_prev_err;
      end else if (c > m_done) begin
        e_count = imin(m_n, 7);
        e_err   = m_err;
      end else begin
        e_busy = 1;
        e_done = (c == m_done);
        nx = 0;
        na = 0;
        for (int i = 0; i < m_n; i++) begin
          if (m_t[i] < c) nx++;
          if (m_t[i] + m_d + 1 <= c) na++;
          if (c >= m_e[i] && c <= m_t[i]) begin
            e_valid = 1;
            e_word  = m_word[i];
          end
        end
        e_count  = imin(nx, 7);
        e_addr   = imin(na, 7);
        chk_addr = 1;
        chk_word = e_valid;
        e_err    = m_err && e_done;
      end
      chk("busy", busy, e_busy);
      chk("issue_valid", issue_valid, e_valid);
      chk("prog_done", prog_done, e_done);
      chk("instr_count", instr_count, e_count);
      chk("prog_err", prog_err, e_err);
      if (chk_addr) chk("instr_mem_addr", instr_mem_addr, e_addr);
      if (chk_word) chk("issue_instr", issue_instr, e_word);
      if (issue_valid && issue_ready) run_xfers++;
      if (prog_done) begin
        run_dones++;
        last_done = c;
      end
    end
  end

  task automatic start_prog(input int d, input int hold, input bit spur, input bit keep);
    @(posedge clk);
    #1;
    acc_enable = 0;
    cfg_d    = d;
    cfg_hold = hold;
    cfg_spur = spur;
    @(posedge clk);
    #1;
    acc_enable = 1;
    run_xfers  = 0;
    run_dones  = 0;
    build_model(cyc, d, hold);
    if (!keep) begin
      @(posedge clk);
      #1;
      acc_enable = 0;
    end
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (run_dones == 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("done_within_budget", (run_dones != 0), 1);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fill_mem(input logic [63:0] fill);
    for (int i = 0; i < 8; i++) mem[i] = fill;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    acc_enable = 0;
    fill_mem(64'hf000_0000_0000_00ff);
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    mon_en = 1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", issue_valid, 0);
    chk("rst_done", prog_done, 0);
    chk("rst_err", prog_err, 0);
    chk("rst_count", instr_count, 0);
    chk("rst_addr", instr_mem_addr, 0);
    chk("rst_instr", issue_instr, 0);

    // 1: three instructions then END, clp_done 4 cycles after each transfer
    fill_mem(64'h7777_0000_0000_0007);
    mem[0] = 64'h1000_0000_0000_0001;
    mem[1] = 64'h2000_0000_0000_0002;
    mem[2] = 64'h3fff_0000_dead_beef;
    mem[3] = END_W;
    start_prog(4, 0, 1, 0);
    wait_done(200);
    chk("t1_xfers", run_xfers, 3);
    chk("t1_dones", run_dones, 1);
    chk("t1_done_lat", last_done - m_s, 28);
    chk("t1_count", instr_count, 3);
    chk("t1_err", prog_err, 0);

    // 2: ready held low 7 cycles in ISSUE
    mem[0] = 64'h5a5a_5a5a_1234_5678;
    mem[1] = END_W;
    start_prog(2, 7, 0, 0);
    wait_done(200);
    chk("t2_xfers", run_xfers, 1);
    chk("t2_done_lat", last_done - m_s, 17);
    chk("t2_count", instr_count, 1);

    // 3: END at address 0
    mem[0] = END_W;
    start_prog(1, 0, 0, 0);
    wait_done(100);
    chk("t3_xfers", run_xfers, 0);
    chk("t3_done_lat", last_done - m_s, 4);
    chk("t3_count", instr_count, 0);

    // 4: no END anywhere -> runs off the end, count saturates, prog_err sticks
    for (int i = 0; i < 8; i++) mem[i] = {4'(i + 1), 60'(i * 17 + 3)};
    start_prog(1, 0, 0, 0);
    wait_done(200);
    chk("t4_xfers", run_xfers, 8);
    chk("t4_done_lat", last_done - m_s, 41);
    chk("t4_count", instr_count, 7);
    chk("t4_err", prog_err, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("t4_err_sticky", prog_err, 1);
    mem[0] = END_W;
    start_prog(1, 0, 0, 0);
    wait_done(100);
    chk("t4b_err_cleared", prog_err, 0);
    chk("t4b_done_lat", last_done - m_s, 4);

    // 5: reset during EXEC of instruction 2, then a fresh start
    mem[0] = 64'hc000_0000_0000_000c;
    mem[1] = 64'hd000_0000_0000_000d;
    mem[2] = 64'he000_0000_0000_000e;
    mem[3] = END_W;
    start_prog(4, 0, 0, 0);
    wait_cyc(m_s + 13);
    chk("t5_in_exec_busy", busy, 1);
    chk("t5_in_exec_count", instr_count, 2);
    rst   = 1;
    m_cut = cyc;
    @(posedge clk);
    #1;
    rst = 0;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_count", instr_count, 0);
    chk("t5_rst_valid", issue_valid, 0);
    repeat (6) @(posedge clk);
    #1;
    chk("t5_no_done_after_rst", run_dones, 0);
    start_prog(1, 0, 1, 0);
    wait_done(200);
    chk("t5_restart_xfers", run_xfers, 3);
    chk("t5_restart_done_lat", last_done - m_s, 19);
    chk("t5_restart_count", instr_count, 3);

    // 6: acc_enable held high across the program -> single run
    mem[0] = 64'h9000_0000_0000_0009;
    mem[1] = 64'ha000_0000_0000_000a;
    mem[2] = END_W;
    start_prog(1, 0, 0, 1);
    wait_done(200);
    repeat (30) @(posedge clk);
    #1;
    chk("t6_xfers", run_xfers, 2);
    chk("t6_dones", run_dones, 1);
    chk("t6_done_lat", last_done - m_s, 14);
    chk("t6_idle", busy, 0);
    acc_enable = 0;
    repeat (3) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
